// File: rtl/sorted_queue_n.sv
// rtl/sorted_queue_n.sv - sorted min-queue keeping entries in non-decreasing order
// Each cycle removes the head and/or inserts one value into its sorted position.
module sorted_queue_n #(
  parameter int n = 4,
  parameter int m = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [n-1:0] push_data_i,
  input  logic         pop_i,
  output logic [n-1:0] min1_o,
  output logic [n-1:0] min2_o,
  output logic [3:0]   count_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  localparam logic [n-1:0] fill_val = '1;
  localparam logic [3:0]   depth    = 4'(m);

  logic [n-1:0] e_q [m];
  logic [m-1:0] v_q;
  logic [3:0]   count_q;
  logic         empty_q, full_q, ovf_q, unf_q;

  logic         push_acc, pop_acc;
  logic [n-1:0] base_e [m];
  logic [m-1:0] base_v;
  logic [m-1:0] lt;
  logic [n-1:0] nxt_e [m];
  logic [m-1:0] nxt_v;
  logic [3:0]   count_n;

  always_comb begin
    push_acc = push_i && (!full_q || pop_i);
    pop_acc  = pop_i && !empty_q;

    // A pop first shifts everything down; a simultaneous push then inserts into the remainder.
    base_e = e_q;
    base_v = v_q;
    if (pop_acc) begin
      for (int i = 0; i < m - 1; i++) base_e[i] = e_q[i+1];
      base_e[m-1] = fill_val;
      base_v      = {1'b0, v_q[m-1:1]};
    end

    // Strict less-than places a new value after any equal ones already stored.
    for (int i = 0; i < m; i++) lt[i] = !base_v[i] || (push_data_i < base_e[i]);

    nxt_e = base_e;
    nxt_v = base_v;
    if (push_acc) begin
      if (lt[0]) begin
        nxt_e[0] = push_data_i;
        nxt_v[0] = 1'b1;
      end
      for (int i = 1; i < m; i++) begin
        if (lt[i]) begin
          nxt_e[i] = lt[i-1] ? base_e[i-1] : push_data_i;
          nxt_v[i] = lt[i-1] ? base_v[i-1] : 1'b1;
        end
      end
    end

    count_n = count_q + {3'b000, push_acc} - {3'b000, pop_acc};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < m; i++) e_q[i] <= fill_val;
      v_q     <= '0;
      count_q <= 4'd0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      e_q     <= nxt_e;
      v_q     <= nxt_v;
      count_q <= count_n;
      empty_q <= (count_n == 4'd0);
      full_q  <= (count_n == depth);
      ovf_q   <= push_i && !pop_i && full_q;
      unf_q   <= pop_i && empty_q;
    end
  end

  assign min1_o      = e_q[0];
  assign min2_o      = e_q[1];
  assign count_o     = count_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: doc/sorted_queue_n.md
SORTED_QUEUE_N -- requirements
Module: sorted_queue_n

Interface
REQ-001 Parameter n, default 4: data width in bits.
REQ-002 Parameter m, default 10: queue depth in entries; legal range 2..15.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 push_i  input  1  insert request, sampled at rising edge.
REQ-006 push_data_i  input  n  value to insert.
REQ-007 pop_i  input  1  remove-smallest request, sampled at rising edge.
REQ-008 min1_o  output  n  smallest stored value; 2^n-1 when empty.
REQ-009 min2_o  output  n  second-smallest stored value; 2^n-1 when fewer than 2 entries.
REQ-010 count_o  output  4  number of valid entries.
REQ-011 empty_o  output  1  high when count_o == 0.
REQ-012 full_o  output  1  high when count_o == m.
REQ-013 overflow_o  output  1  one-cycle pulse on a rejected push.
REQ-014 underflow_o  output  1  one-cycle pulse on an ignored pop.

Function
REQ-015 Storage: m registered entries e[0..m-1], each with a valid bit; valid entries contiguous from e[0], kept in non-decreasing order.
REQ-016 Invalid entries hold 2^n-1.
REQ-017 min1_o = e[0]; min2_o = e[1]; both driven directly from registers, no combinational path from inputs.
REQ-018 Push-only, not full: push_data_i inserted at the lowest index k where e[k] is invalid or push_data_i < e[k] (strict compare); entries k..count-1 shift up one; count +1.
REQ-019 Equal values: a new value is placed after existing equal values (stable order).
REQ-020 Pop-only, not empty: e[1..m-1] shift down to e[0..m-2]; e[m-1] becomes invalid, 2^n-1; count -1.
REQ-021 Push and pop in the same cycle, not empty: the old e[0] is removed and push_data_i is inserted into the remaining entries in that one cycle; count unchanged; full_o unchanged.
REQ-022 Push and pop in the same cycle while full: both accepted per REQ-021; overflow_o stays low.
REQ-023 Push without pop while full: push rejected, state unchanged, overflow_o = 1 for the next cycle.
REQ-024 Pop while empty: pop ignored, underflow_o = 1 for the next cycle.
REQ-025 Push and pop in the same cycle while empty: push accepted (count becomes 1), pop ignored, underflow_o = 1.
REQ-026 Latency: an accepted push or pop is reflected on min1_o, min2_o, count_o, empty_o and full_o one clock after the sampling edge.
REQ-027 overflow_o and underflow_o are registered, high for exactly one cycle per event, and low otherwise.
REQ-028 All comparisons are unsigned over n bits; no width extension or truncation of stored data.

Reset
REQ-029 rst_i low asynchronously forces all entries to 2^n-1 and all valid bits to 0.
REQ-030 During reset: count_o = 0, empty_o = 1, full_o = 0, min1_o = min2_o = 2^n-1, overflow_o = underflow_o = 0.
REQ-031 Reset asserted during a push or pop discards that operation; no partial shift remains.
REQ-032 The first rising edge after rst_i deasserts samples inputs normally.

Verification (n=4, m=10)
REQ-033 Push 7, 3, 9, 3 on consecutive cycles -> after the last push: min1_o=3, min2_o=3, count_o=4; then pop x4 -> min1_o sequence 3, 7, 9, 15; empty_o=1.
REQ-034 Push 10 values 9..0 -> full_o=1, count_o=10, min1_o=0, min2_o=1; an 11th push of 5 -> overflow_o pulse, state unchanged.
REQ-035 While full, push 2 and pop in the same cycle -> count_o stays 10; min1_o=1, min2_o=2; no overflow_o pulse.
REQ-036 From reset, pop -> underflow_o pulse, count_o=0; push 4 and pop in the same cycle -> count_o=1, min1_o=4, underflow_o pulse.
REQ-037 Push 6 and 8, then assert rst_i low mid-cycle during a push of 1 -> outputs return to reset values immediately; after release, min1_o=15 and count_o=0.
REQ-038 Random push/pop for 2000 cycles against a sorted-list model -> min1_o, min2_o, count_o, full_o, empty_o and both pulse outputs match every cycle.
